// File: rtl/vga_layer_pkg.sv
// vga_layer_pkg: config word field positions and config FSM states for the layer arbiter
package vga_layer_pkg;
    localparam int CFG_EN_LSB         = 0;
    localparam int CFG_MODE_BIT       = 4;
    localparam int CFG_BG_LSB         = 5;
    localparam int CFG_BLINK_MASK_LSB = 11;
    localparam int CFG_BLINK_PER_LSB  = 15;
    localparam int CFG_BLINK_PER_W    = 6;
    localparam int CFG_USED_W         = 21;
    typedef enum logic {IDLE, PEND} cfg_state_t;
endpackage

// File: rtl/layer_priority_pick.sv
// layer_priority_pick: combinational first-one finder that starts at a given index and wraps
module layer_priority_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  eff,
    input  logic [IW-1:0] start,
    output logic          hit,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] k;
    always_comb begin
        hit = |eff;
        idx = '0;
        k   = '0;
        // Walk from the farthest offset down so the nearest set bit overwrites last
        for (int i = N - 1; i >= 0; i--) begin
            k = IW'((int'(start) + i) % N);
            if (eff[k]) idx = k;
        end
    end
endmodule

// File: rtl/vga_layer_arbiter.sv
// vga_layer_arbiter: per-pixel layer compositor with frame-synchronous config updates
module vga_layer_arbiter
    import vga_layer_pkg::*;
#(
    parameter int          NUM_SRC   = 4,
    parameter int          COLOR_W   = 6,
    parameter logic [31:0] RESET_CFG = 32'h0000_000F
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       cfg_valid,
    input  logic [31:0]                cfg_data,
    output logic                       cfg_ready,
    input  logic                       vs,
    input  logic                       video_active,
    input  logic [NUM_SRC-1:0]         src_pixel,
    input  logic [NUM_SRC*COLOR_W-1:0] src_color,
    output logic [COLOR_W-1:0]         rgb_out,
    output logic                       pix_valid,
    output logic [$clog2(NUM_SRC)-1:0] active_src,
    output logic [7:0]                 frame_count,
    output logic                       cfg_applied
);
    localparam int IW = $clog2(NUM_SRC);

    cfg_state_t                  state;
    logic [CFG_USED_W-1:0]       shadow, pending;
    logic                        vs_d, blink_phase, fb;
    logic [CFG_BLINK_PER_W-1:0]  blink_cnt, blink_per;
    logic [IW-1:0]               rot_ptr;
    logic [NUM_SRC-1:0]          en_mask, blink_mask, eff_s1;
    logic [NUM_SRC*COLOR_W-1:0]  color_s1;
    logic                        va_s1, mode, hit;
    logic [COLOR_W-1:0]          bg;
    logic [IW-1:0]               win;
    logic                        unused_cfg_bits;

    assign unused_cfg_bits = ^cfg_data[31:CFG_USED_W];
    assign fb         = vs_d && !vs;
    assign cfg_ready  = state == IDLE;
    assign en_mask    = shadow[CFG_EN_LSB +: NUM_SRC];
    assign mode       = shadow[CFG_MODE_BIT];
    assign bg         = shadow[CFG_BG_LSB +: COLOR_W];
    assign blink_mask = shadow[CFG_BLINK_MASK_LSB +: NUM_SRC];
    assign blink_per  = shadow[CFG_BLINK_PER_LSB +: CFG_BLINK_PER_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shadow      <= RESET_CFG[CFG_USED_W-1:0];
            pending     <= '0;
            vs_d        <= 1'b0;
            blink_phase <= 1'b0;
            blink_cnt   <= '0;
            rot_ptr     <= '0;
            frame_count <= '0;
            cfg_applied <= 1'b0;
        end else if (enable) begin
            vs_d        <= vs;
            cfg_applied <= fb && state == PEND;
            if (state == IDLE && cfg_valid) begin
                pending <= cfg_data[CFG_USED_W-1:0];
                state   <= PEND;
            end
            if (fb) begin
                frame_count <= frame_count + 8'd1;
                if (state == PEND) begin
                    shadow      <= pending;
                    state       <= IDLE;
                    blink_cnt   <= '0;
                    blink_phase <= 1'b0;
                    rot_ptr     <= '0;
                end else begin
                    blink_cnt   <= (blink_per == 0 || blink_cnt >= blink_per - 1'b1) ? '0 : blink_cnt + 1'b1;
                    blink_phase <= blink_per != 0 && (blink_cnt >= blink_per - 1'b1) ? !blink_phase : blink_phase;
                    rot_ptr     <= !mode ? '0 : (rot_ptr == IW'(NUM_SRC - 1)) ? '0 : rot_ptr + 1'b1;
                end
            end
        end
    end

    layer_priority_pick #(.N(NUM_SRC), .IW(IW)) u_pick (
        .eff   (eff_s1),
        .start (mode ? rot_ptr : '0),
        .hit   (hit),
        .idx   (win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eff_s1     <= '0;
            color_s1   <= '0;
            va_s1      <= 1'b0;
            rgb_out    <= '0;
            pix_valid  <= 1'b0;
            active_src <= '0;
        end else if (enable) begin
            eff_s1     <= src_pixel & en_mask & ~(blink_mask & {NUM_SRC{blink_phase}});
            color_s1   <= src_color;
            va_s1      <= video_active;
            rgb_out    <= !va_s1 ? '0 : hit ? color_s1[win*COLOR_W +: COLOR_W] : bg;
            pix_valid  <= va_s1;
            active_src <= hit ? win : '0;
        end
    end
endmodule

// File: tb/tb_vga_layer_arbiter.sv
// tb_vga_layer_arbiter: directed-vector bench for the VGA layer arbiter
module tb_vga_layer_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, enable, cfg_valid, cfg_ready, vs, video_active;
    logic [31:0] cfg_data;
    logic [3:0]  src_pixel;
    logic [23:0] src_color;
    logic [5:0]  rgb_out;
    logic        pix_valid, cfg_applied;
    logic [1:0]  active_src;
    logic [7:0]  frame_count;
    int          n_checks = 0;
    int          n_pass   = 0;

    vga_layer_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_data     (cfg_data),
        .cfg_ready    (cfg_ready),
        .vs           (vs),
        .video_active (video_active),
        .src_pixel    (src_pixel),
        .src_color    (src_color),
        .rgb_out      (rgb_out),
        .pix_valid    (pix_valid),
        .active_src   (active_src),
        .frame_count  (frame_count),
        .cfg_applied  (cfg_applied)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // vs low for exactly one cycle: the frame boundary lands on the posedge inside
    task automatic pulse_vs();
        vs = 1'b0;
        @(negedge clk);
        vs = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; cfg_valid = 1'b0; cfg_data = '0;
        vs = 1'b1; video_active = 1'b1; src_pixel = 4'b0000;
        src_color = {6'h3F, 6'h0C, 6'h30, 6'h03};
        tick(1);
        check("rst_rgb", rgb_out, 6'h00);
        check("rst_pv", pix_valid, 1'b0);
        check("rst_src", active_src, 2'd0);
        check("rst_fc", frame_count, 8'd0);
        check("rst_applied", cfg_applied, 1'b0);
        check("rst_ready", cfg_ready, 1'b1);
        rst_n = 1'b1;
        tick(2);
        check("bg_rgb", rgb_out, 6'h00);
        check("bg_pv", pix_valid, 1'b1);
        check("bg_ready", cfg_ready, 1'b1);

        src_pixel = 4'b0110;
        tick(1);
        check("lat1_rgb", rgb_out, 6'h00);
        check("lat1_src", active_src, 2'd0);
        tick(1);
        check("fixed_rgb", rgb_out, 6'h30);
        check("fixed_src", active_src, 2'd1);

        cfg_valid = 1'b1; cfg_data = 32'h0000_0409;
        tick(1);
        check("pend_ready", cfg_ready, 1'b0);
        cfg_data = 32'h0000_001F;
        tick(3);
        check("pend_rgb_hold", rgb_out, 6'h30);
        check("pend_ready2", cfg_ready, 1'b0);
        check("pend_no_apply", cfg_applied, 1'b0);
        pulse_vs();
        check("apply_pulse", cfg_applied, 1'b1);
        check("apply_fc", frame_count, 8'd1);
        check("apply_ready", cfg_ready, 1'b1);
        tick(1);
        check("apply_once", cfg_applied, 1'b0);
        check("second_taken", cfg_ready, 1'b0);
        cfg_valid = 1'b0;
        tick(1);
        check("mask_bg_rgb", rgb_out, 6'h20);
        check("mask_bg_src", active_src, 2'd0);

        src_pixel = 4'b1111;
        pulse_vs();
        check("apply2_pulse", cfg_applied, 1'b1);
        tick(2);
        check("rot0_src", active_src, 2'd0);
        check("rot0_rgb", rgb_out, 6'h03);
        pulse_vs(); tick(1);
        check("rot1_src", active_src, 2'd1);
        check("rot1_rgb", rgb_out, 6'h30);
        pulse_vs(); tick(1);
        check("rot2_src", active_src, 2'd2);
        check("rot2_rgb", rgb_out, 6'h0C);
        pulse_vs(); tick(1);
        check("rot3_src", active_src, 2'd3);
        check("rot3_rgb", rgb_out, 6'h3F);
        pulse_vs(); tick(1);
        check("rot4_src", active_src, 2'd0);
        check("rot_fc", frame_count, 8'd6);

        video_active = 1'b0;
        tick(2);
        check("blank_rgb", rgb_out, 6'h00);
        check("blank_pv", pix_valid, 1'b0);
        video_active = 1'b1;

        src_pixel = 4'b0001;
        cfg_valid = 1'b1; cfg_data = 32'h0001_0AAF;
        tick(1);
        cfg_valid = 1'b0;
        pulse_vs(); tick(2);
        check("blink_f0", rgb_out, 6'h03);
        pulse_vs(); tick(2);
        check("blink_f1", rgb_out, 6'h03);
        pulse_vs(); tick(2);
        check("blink_f2", rgb_out, 6'h15);
        pulse_vs(); tick(2);
        check("blink_f3", rgb_out, 6'h15);
        pulse_vs(); tick(2);
        check("blink_f4", rgb_out, 6'h03);

        #2 rst_n = 1'b0;
        #1;
        check("async_rgb", rgb_out, 6'h00);
        check("async_pv", pix_valid, 1'b0);
        check("async_fc", frame_count, 8'd0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        enable = 1'b0;
        vs = 1'b0;
        tick(2);
        vs = 1'b1;
        tick(2);
        enable = 1'b1;
        tick(2);
        check("freeze_fc", frame_count, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
